// File: rtl/vga_sram_pixel_fetch.sv
`default_nettype none
// ============================================================================
// Module      : vga_sram_pixel_fetch
// Description : Double-buffered 320x240 RGB565 SRAM scan-out, pixel-doubled
//               to a 640x480 VGA window with sync re-aligned to the pixels.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sram_pixel_fetch #(
  parameter logic [9:0]  H_ACT_START = 10'd145,
  parameter logic [9:0]  H_ACT_END   = 10'd784,
  parameter logic [9:0]  V_ACT_START = 10'd36,
  parameter logic [9:0]  V_ACT_END   = 10'd515,
  parameter logic [17:0] BUF1_BASE   = 18'h20000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [9:0]  qc1,
  input  logic [9:0]  qc2,
  input  logic        HSYNC_i,
  input  logic        VSYNC_i,
  input  logic        swap_req,
  input  logic [15:0] sram_dq_i,
  output logic [17:0] sram_addr,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic [4:0]  vga_r,
  output logic [5:0]  vga_g,
  output logic [4:0]  vga_b,
  output logic        HSYNC_o,
  output logic        VSYNC_o,
  output logic        frame_start,
  output logic        swap_ack,
  output logic        buf_sel
);

  localparam logic [1:0] c_SYNC_WAIT = 2'd0;
  localparam logic [1:0] c_VBLANK    = 2'd1;
  localparam logic [1:0] c_ACTIVE    = 2'd2;

  logic [1:0]  r_state;
  logic [17:0] r_base;
  logic        r_act1;
  logic        r_act2;
  logic [15:0] r_data;
  logic [2:0]  r_hs_dly;
  logic [2:0]  r_vs_dly;

  logic        w_at_start;
  logic        w_at_end;
  logic        w_in_win;
  logic        w_act;
  logic        w_swap;
  logic [9:0]  w_hoff;
  logic [9:0]  w_voff;
  logic [17:0] w_col;
  logic [17:0] w_row;
  logic [17:0] w_row_x320;
  logic [17:0] w_base_cur;
  logic [17:0] w_pix_addr;
  logic        w_unused_bits;

  assign w_at_start = (qc2 == V_ACT_START) && (qc1 == H_ACT_START);
  assign w_at_end   = (qc2 == V_ACT_END) && (qc1 == H_ACT_END);
  assign w_in_win   = (qc1 >= H_ACT_START) && (qc1 <= H_ACT_END) &&
                      (qc2 >= V_ACT_START) && (qc2 <= V_ACT_END);

  // The VBLANK->ACTIVE cycle already issues the first pixel address.
  assign frame_start = (r_state == c_VBLANK) && w_at_start;
  assign w_act       = ((r_state == c_ACTIVE) || frame_start) && w_in_win;
  assign w_swap      = (r_state == c_ACTIVE) && w_at_end && swap_req;

  assign w_hoff        = qc1 - H_ACT_START;
  assign w_voff        = qc2 - V_ACT_START;
  assign w_col         = {9'd0, w_hoff[9:1]};
  assign w_row         = {10'd0, w_voff[8:1]};
  assign w_row_x320    = (w_row << 8) + (w_row << 6);
  assign w_base_cur    = frame_start ? (buf_sel ? BUF1_BASE : 18'd0) : r_base;
  assign w_pix_addr    = w_base_cur + w_row_x320 + w_col;
  assign w_unused_bits = &{1'b0, w_hoff[0], w_voff[9], w_voff[0]};

  assign sram_we_n = 1'b1;
  assign HSYNC_o   = r_hs_dly[2];
  assign VSYNC_o   = r_vs_dly[2];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= c_SYNC_WAIT;
      r_base   <= 18'd0;
      buf_sel  <= 1'b0;
      swap_ack <= 1'b0;
    end else begin
      swap_ack <= w_swap;
      if (w_swap) begin
        buf_sel <= ~buf_sel;
      end
      if (frame_start) begin
        r_base <= w_base_cur;
      end
      case (r_state)
        c_SYNC_WAIT: if (!VSYNC_i)    r_state <= c_VBLANK;
        c_VBLANK:    if (w_at_start)  r_state <= c_ACTIVE;
        c_ACTIVE:    if (w_at_end)    r_state <= c_VBLANK;
        default:                      r_state <= c_SYNC_WAIT;
      endcase
    end
  end

  // Three-stage pipe: address, SRAM data capture, colour out.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sram_addr <= 18'd0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      r_act1    <= 1'b0;
      r_act2    <= 1'b0;
      r_data    <= 16'd0;
      vga_r     <= 5'd0;
      vga_g     <= 6'd0;
      vga_b     <= 5'd0;
      r_hs_dly  <= 3'b111;
      r_vs_dly  <= 3'b111;
    end else begin
      if (w_act) begin
        sram_addr <= w_pix_addr;
      end
      sram_ce_n <= ~w_act;
      sram_oe_n <= ~w_act;
      r_act1    <= w_act;
      r_act2    <= r_act1;
      r_data    <= sram_dq_i;
      vga_r     <= r_act2 ? r_data[15:11] : 5'd0;
      vga_g     <= r_act2 ? r_data[10:5]  : 6'd0;
      vga_b     <= r_act2 ? r_data[4:0]   : 5'd0;
      r_hs_dly  <= {r_hs_dly[1:0], HSYNC_i};
      r_vs_dly  <= {r_vs_dly[1:0], VSYNC_i};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_sram_pixel_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_sram_pixel_fetch
// Description : Self-checking bench for vga_sram_pixel_fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sram_pixel_fetch;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [9:0]  qc1 = 10'd1;
  logic [9:0]  qc2 = 10'd1;
  logic        HSYNC_i = 1'b1;
  logic        VSYNC_i = 1'b1;
  logic        swap_req = 1'b0;
  logic [15:0] sram_dq_i;
  logic [17:0] sram_addr;
  logic        sram_ce_n, sram_oe_n, sram_we_n;
  logic [4:0]  vga_r, vga_b;
  logic [5:0]  vga_g;
  logic        HSYNC_o, VSYNC_o, frame_start, swap_ack, buf_sel;

  vga_sram_pixel_fetch dut (
    .CLK(CLK), .RST(RST), .qc1(qc1), .qc2(qc2),
    .HSYNC_i(HSYNC_i), .VSYNC_i(VSYNC_i), .swap_req(swap_req),
    .sram_dq_i(sram_dq_i), .sram_addr(sram_addr),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .HSYNC_o(HSYNC_o), .VSYNC_o(VSYNC_o), .frame_start(frame_start),
    .swap_ack(swap_ack), .buf_sel(buf_sel)
  );

  always #20 CLK = ~CLK;

  // SRAM contents: low address bits, with the buffer bits folded in.
  function automatic logic [15:0] sram_word(input logic [17:0] a);
    return a[15:0] ^ {14'd0, a[17:16]};
  endfunction

  assign sram_dq_i = sram_word(sram_addr);

  int checks   = 0;
  int failures = 0;

  // Reference model: frame/buffer bookkeeping plus a 3-deep history of
  // what each past cycle should have produced.
  bit m_armed, m_scan, m_buf, m_ack, host_want;
  int m_base, m_addr;
  bit h_act[3];
  int h_adr[3];
  bit h_hs[3];
  bit h_vs[3];

  typedef struct {
    int q1;
    int q2;
    int addr;
    bit ce_n;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t (qc1=%0d qc2=%0d)", nm, got, exp, $time, qc1, qc2);
    end
  endtask

  task automatic model_reset();
    m_armed = 0; m_scan = 0; m_buf = 0; m_ack = 0; host_want = 0;
    m_base = 0; m_addr = 0;
    for (int i = 0; i < 3; i++) begin
      h_act[i] = 0; h_adr[i] = 0; h_hs[i] = 1; h_vs[i] = 1;
    end
  endtask

  // One pixel clock with counters (q1,q2); called at posedge+1.
  task automatic cyc(input int q1, input int q2);
    bit hs, vs, start, endp, win, fs, act;
    int base_now;
    logic [15:0] ed;
    hs = !(q1 >= 1 && q1 <= 96);
    vs = !(q2 >= 1 && q2 <= 2);
    qc1 = q1[9:0]; qc2 = q2[9:0];
    HSYNC_i = hs; VSYNC_i = vs; swap_req = host_want;
    start = (q1 == 145) && (q2 == 36);
    endp  = (q1 == 784) && (q2 == 515);
    win   = (q1 >= 145) && (q1 <= 784) && (q2 >= 36) && (q2 <= 515);
    fs    = m_armed && !m_scan && start;
    act   = (m_scan || fs) && win;
    @(negedge CLK);
    ed = h_act[2] ? sram_word(18'(h_adr[2])) : 16'd0;
    chk("sram_addr", 32'(sram_addr), 32'(m_addr));
    chk("sram_ce_n", 32'(sram_ce_n), 32'(!h_act[0]));
    chk("sram_oe_n", 32'(sram_oe_n), 32'(!h_act[0]));
    chk("sram_we_n", 32'(sram_we_n), 32'd1);
    chk("vga_r", 32'(vga_r), 32'(ed[15:11]));
    chk("vga_g", 32'(vga_g), 32'(ed[10:5]));
    chk("vga_b", 32'(vga_b), 32'(ed[4:0]));
    chk("HSYNC_o", 32'(HSYNC_o), 32'(h_hs[2]));
    chk("VSYNC_o", 32'(VSYNC_o), 32'(h_vs[2]));
    chk("frame_start", 32'(frame_start), 32'(fs));
    chk("swap_ack", 32'(swap_ack), 32'(m_ack));
    chk("buf_sel", 32'(buf_sel), 32'(m_buf));
    base_now = fs ? (m_buf ? 32'h20000 : 0) : m_base;
    if (act) m_addr = base_now + ((q2 - 36) / 2) * 320 + (q1 - 145) / 2;
    for (int i = 2; i > 0; i--) begin
      h_act[i] = h_act[i-1]; h_adr[i] = h_adr[i-1];
      h_hs[i] = h_hs[i-1]; h_vs[i] = h_vs[i-1];
    end
    h_act[0] = act; h_adr[0] = m_addr; h_hs[0] = hs; h_vs[0] = vs;
    m_ack = m_scan && endp && host_want;
    if (m_ack) begin
      m_buf = !m_buf;
      host_want = 0;
    end
    if (fs) begin
      m_base = base_now;
      m_scan = 1;
    end else if (m_scan && endp) begin
      m_scan = 0;
    end
    if (!vs) m_armed = 1;
    @(posedge CLK);
    #1;
  endtask

  task automatic row_cols(input int r);
    int c1, c2;
    c1 = 151 + int'($urandom % 300);
    c2 = c1 + 1 + int'($urandom % (779 - c1));
    cyc(1, r); cyc(2, r); cyc(96, r); cyc(97, r);
    for (int c = 143; c <= 150; c++) cyc(c, r);
    cyc(c1, r); cyc(c2, r);
    for (int c = 781; c <= 786; c++) cyc(c, r);
    cyc(800, r);
    if ($urandom % 3 == 0) cyc(($urandom % 2 == 0) ? 0 : 1023, r);
  endtask

  // Compressed frame: only rows >= first_row are visited.
  task automatic run_rows(input int first_row, input bit rnd_swap);
    int rows[$];
    int ra;
    ra = 39 + int'($urandom % 150);
    rows = {1, 2, 3, 35, 36, 37, 38, ra, ra + 1 + int'($urandom % 150), 514, 515, 516, 600, 525};
    foreach (rows[i]) begin
      if (rows[i] >= first_row) begin
        if (rnd_swap && !host_want && ($urandom % 4 == 0)) host_want = 1;
        row_cols(rows[i]);
      end
    end
  endtask

  initial begin
    tbl[0] = '{146, 36, 0, 0};
    tbl[1] = '{147, 36, 1, 0};
    tbl[2] = '{148, 36, 1, 0};
    tbl[3] = '{145, 38, 320, 0};
    tbl[4] = '{146, 37, 0, 0};
    tbl[5] = '{784, 36, 319, 0};
    tbl[6] = '{161, 100, 10248, 0};
    tbl[7] = '{600, 300, 42467, 0};
    tbl[8] = '{783, 514, 76799, 0};
    tbl[9] = '{785, 300, 76799, 1};

    model_reset();
    qc1 = 10'd300; qc2 = 10'd200;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_ce_n", 32'(sram_ce_n), 32'd1);
    chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
    chk("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
    chk("rst_sync", 32'({HSYNC_o, VSYNC_o}), 32'd3);
    chk("rst_flags", 32'({frame_start, swap_ack, buf_sel}), 32'd0);

    // Release mid-frame: nothing may be fetched before the first VSYNC.
    @(posedge CLK); #1;
    RST = 1'b0;
    run_rows(200, 0);

    // First real frame: table of address mapping points.
    cyc(1, 1); cyc(2, 2); cyc(150, 35);
    cyc(145, 36);
    chk("first_addr", 32'(sram_addr), 32'd0);
    foreach (tbl[i]) begin
      cyc(tbl[i].q1, tbl[i].q2);
      chk("tbl_addr", 32'(sram_addr), 32'(tbl[i].addr));
      chk("tbl_ce_n", 32'(sram_ce_n), 32'(tbl[i].ce_n));
    end
    for (int c = 782; c <= 787; c++) cyc(c, 515);
    row_cols(516);

    // Swap requested mid-frame takes effect at end of this frame.
    run_rows(1, 0);
    cyc(1, 1); cyc(2, 2);
    row_cols(36); row_cols(200);
    host_want = 1;
    row_cols(300); row_cols(515); row_cols(525);
    chk("swap_done", 32'(buf_sel), 32'd1);

    // Next frame scans buffer 1; then reset while active.
    cyc(1, 1); cyc(2, 2);
    cyc(145, 36);
    chk("buf1_addr", 32'(sram_addr), 32'h20000);
    for (int c = 146; c <= 160; c++) cyc(c, 36);
    RST = 1'b1;
    #2;
    chk("midrst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
    chk("midrst_sync", 32'({HSYNC_o, VSYNC_o}), 32'd3);
    chk("midrst_buf", 32'(buf_sel), 32'd0);
    chk("midrst_ce", 32'({sram_ce_n, sram_oe_n}), 32'd3);
    chk("midrst_addr", 32'(sram_addr), 32'd0);
    model_reset();
    qc1 = 10'd300; qc2 = 10'd200;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    run_rows(200, 0);

    // Randomized frames with host swap requests.
    for (int f = 0; f < 5; f++) run_rows(1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
